lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 59 +++++
 rtl/lsu_load_align.sv | 40 ++++
 rtl/lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_lsu.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Purpose: Shared definitions for the load/store unit. Holds the opcode
//          constants, the funct3 load/store encodings, the LSU state encoding,
//          the default bus timeout, and small helpers for byte-lane enables
//          and store-data replication.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  // funct3 load encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // funct3 store encodings
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Default number of cycles to wait for a bus acknowledge
  localparam int LSU_BUS_TIMEOUT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_t;

  // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate store data so every lane the byte enables may select is valid.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module : lsu_load_align
// Purpose: Combinational extraction of load data from a 32-bit bus word.
//          Selects the addressed byte/halfword lane and sign- or zero-extends
//          it according to funct3. Unknown load encodings return zero.
// Ports  : rdata  in  32  word returned by the bus
//          addr   in   2  byte offset within the word
//          funct3 in   3  load encoding
//          result out 32  value written back to the register file
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    // Bring the addressed lane down to bit 0; words are always at offset 0.
    shifted = rdata >> {addr, 3'b000};
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   result = shifted;
      F3_LBU:  result = {24'd0, shifted[7:0]};
      F3_LHU:  result = {16'd0, shifted[15:0]};
      default: result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module : lsu
// Purpose: Load/store unit between the execute stage and a simple req/ack bus.
//          Issues the bus request combinationally in IDLE, waits in WAIT for
//          the acknowledge (with a timeout), generates byte enables and
//          replicated store data, aligns load data, and registers the
//          write-back with one cycle of latency.
// Config : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses
//          raise misalign_o instead of a bus access; when undefined the low
//          address bits are masked to natural alignment.
// Ports  : clk, arst_n                 clock, async active-low reset
//          inst_i, mem_*_i, reg_w_*_i  execute-stage request
//          bus_*_o / bus_*_i           memory bus
//          reg_w_*_o                   registered write-back
//          hold_o                      pipeline stall request
//          bus_err_o, misalign_o       one-cycle error pulses
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int BUS_TIMEOUT = LSU_BUS_TIMEOUT
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [31:0] inst_i,
  input  logic        mem_r_ena_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] mem_r_addr_i,
  input  logic [31:0] mem_w_addr_i,
  input  logic [31:0] mem_w_data_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic [31:0] reg_w_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        reg_w_ena_o,
  output logic [4:0]  reg_w_addr_o,
  output logic [31:0] reg_w_data_o,
  output logic        hold_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam int               CNT_W   = $clog2(BUS_TIMEOUT);
  // The request cycle in IDLE counts toward the budget, so WAIT lasts
  // BUS_TIMEOUT-1 cycles: counter values 0 .. BUS_TIMEOUT-2.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUS_TIMEOUT - 2);

  lsu_state_t       state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt;

  logic [2:0]  funct3;
  logic [1:0]  size;
  logic        is_store;
  logic        access;
  logic [31:0] req_addr;
  logic [1:0]  raw_a;
  logic [1:0]  lane_a;
  logic        misaligned;
  logic        new_req;
  logic [31:0] new_addr;
  logic [31:0] new_wdata;
  logic [3:0]  new_be;

  // Request captured while in IDLE and replayed unchanged throughout WAIT
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_a;
  logic [4:0]  lat_rd;
  logic        lat_rd_ena;

  logic        in_wait;
  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [1:0]  cur_a;
  logic [4:0]  cur_rd;
  logic        cur_rd_ena;
  logic        ack_ok;
  logic        timeout;
  logic [31:0] load_data;

  logic        unused_bits;
  assign unused_bits = ^{inst_i[31:15], inst_i[11:0]};

  // ---------------------------------------------------------------- request
  assign funct3   = inst_i[14:12];
  assign size     = funct3[1:0];
  assign is_store = mem_w_ena_i;            // store wins when both are set
  // Gating with reset keeps the bus quiet while reset is held.
  assign access   = arst_n & (mem_r_ena_i | mem_w_ena_i);
  assign req_addr = is_store ? mem_w_addr_i : mem_r_addr_i;
  assign raw_a    = req_addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((size == 2'b01) & raw_a[0]) | (size[1] & (raw_a != 2'b00));
  assign lane_a     = raw_a;
`else
  assign misaligned = 1'b0;
  assign lane_a     = (size == 2'b00) ? raw_a :
                      (size == 2'b01) ? {raw_a[1], 1'b0} : 2'b00;
`endif

  assign new_req   = access & ~misaligned;
  assign new_addr  = {req_addr[31:2], 2'b00};
  assign new_be    = lane_be(size, lane_a);
  assign new_wdata = lane_wdata(size, mem_w_data_i);

  // ---------------------------------------------------------------- bus side
  assign in_wait     = (state == ST_WAIT);
  assign bus_req_o   = in_wait ? 1'b1       : new_req;
  assign bus_we_o    = in_wait ? lat_we     : is_store;
  assign bus_addr_o  = in_wait ? lat_addr   : new_addr;
  assign bus_wdata_o = in_wait ? lat_wdata  : new_wdata;
  assign bus_be_o    = in_wait ? lat_be     : new_be;

  assign cur_we      = bus_we_o;
  assign cur_funct3  = in_wait ? lat_funct3 : funct3;
  assign cur_a       = in_wait ? lat_a      : lane_a;
  assign cur_rd      = in_wait ? lat_rd     : reg_w_addr_i;
  assign cur_rd_ena  = in_wait ? lat_rd_ena : reg_w_ena_i;

  // An acknowledge only counts while a request is outstanding.
  assign ack_ok  = bus_req_o & bus_ack_i;
  assign hold_o  = bus_req_o & ~bus_ack_i;
  assign timeout = in_wait & ~bus_ack_i & (tmo_cnt == TO_LAST);

  lsu_load_align u_load_align (
    .rdata  (bus_rdata_i),
    .addr   (cur_a),
    .funct3 (cur_funct3),
    .result (load_data)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      // Held at zero in IDLE, so every entry to WAIT starts a fresh count.
      tmo_cnt <= in_wait ? tmo_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (new_req & ~bus_ack_i)  state_nxt = ST_WAIT;
      ST_WAIT: if (bus_ack_i | timeout)   state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_funct3 <= '0;
      lat_a      <= '0;
      lat_rd     <= '0;
      lat_rd_ena <= 1'b0;
    end else if (!in_wait) begin
      lat_we     <= is_store;
      lat_addr   <= new_addr;
      lat_wdata  <= new_wdata;
      lat_be     <= new_be;
      lat_funct3 <= funct3;
      lat_a      <= lane_a;
      lat_rd     <= reg_w_addr_i;
      lat_rd_ena <= reg_w_ena_i;
    end
  end

  // ---------------------------------------------------------------- write-back
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      reg_w_ena_o  <= 1'b0;
      reg_w_addr_o <= '0;
      reg_w_data_o <= '0;
      bus_err_o    <= 1'b0;
    end else begin
      bus_err_o <= timeout;
      if (ack_ok & ~cur_we) begin
        reg_w_ena_o  <= cur_rd_ena;
        reg_w_addr_o <= cur_rd;
        reg_w_data_o <= load_data;
      end else if (!in_wait && !access) begin
        reg_w_ena_o  <= reg_w_ena_i;
        reg_w_addr_o <= reg_w_addr_i;
        reg_w_data_o <= reg_w_data_i;
      end else begin
        // Stores, pending accesses, timeouts and traps write nothing back.
        reg_w_ena_o  <= 1'b0;
        reg_w_addr_o <= '0;
        reg_w_data_o <= '0;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) misalign_o <= 1'b0;
    else         misalign_o <= ~in_wait & access & misaligned;
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module : tb_lsu
// Purpose: Self-checking bench for lsu. Drives directed load/store/ALU
//          traffic, models expected write-backs in a queue, and compares bus
//          outputs, stall, error pulses and write-back data/timing.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] inst_i;
  logic        mem_r_ena_i, mem_w_ena_i;
  logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_w_data_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] reg_w_data_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;
  logic        hold_o, bus_err_o, misalign_o;

  always #5 clk = ~clk;

  lsu #(.BUS_TIMEOUT(16)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .inst_i       (inst_i),
    .mem_r_ena_i  (mem_r_ena_i),
    .mem_w_ena_i  (mem_w_ena_i),
    .mem_r_addr_i (mem_r_addr_i),
    .mem_w_addr_i (mem_w_addr_i),
    .mem_w_data_i (mem_w_data_i),
    .reg_w_ena_i  (reg_w_ena_i),
    .reg_w_addr_i (reg_w_addr_i),
    .reg_w_data_i (reg_w_data_i),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_be_o     (bus_be_o),
    .bus_ack_i    (bus_ack_i),
    .bus_rdata_i  (bus_rdata_i),
    .reg_w_ena_o  (reg_w_ena_o),
    .reg_w_addr_o (reg_w_addr_o),
    .reg_w_data_o (reg_w_data_o),
    .hold_o       (hold_o),
    .bus_err_o    (bus_err_o),
    .misalign_o   (misalign_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wb_exp_t;

  wb_exp_t sb[$];
  wb_exp_t mon_e;
  int      tests_run    = 0;
  int      tests_failed = 0;
  int      cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Write-back monitor: every write-back must match the head of the queue,
  // and arrive exactly in the cycle the model predicted.
  always @(negedge clk) begin
    if (arst_n === 1'b1) begin
      if (reg_w_ena_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", {31'd0, reg_w_ena_o}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wb_rd",    {27'd0, reg_w_addr_o}, {27'd0, mon_e.rd});
          check("wb_data",  reg_w_data_o, mon_e.data);
          check("wb_cycle", cyc, mon_e.cyc);
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        check("wb_missing", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    inst_i       = {25'd0, OPC_OP};
    mem_r_ena_i  = 1'b0;
    mem_w_ena_i  = 1'b0;
    mem_r_addr_i = 32'd0;
    mem_w_addr_i = 32'd0;
    mem_w_data_i = 32'd0;
    reg_w_ena_i  = 1'b0;
    reg_w_addr_i = 5'd0;
    reg_w_data_i = 32'd0;
    bus_ack_i    = 1'b0;
    bus_rdata_i  = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One bus access acknowledged after 'waits' stalled cycles. Called just
  // after a rising edge; returns just after the completing edge.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rword, input logic [4:0] rd,
                        input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_res);
    inst_i       = {17'd0, f3, 5'd0, st ? OPC_STORE : OPC_LOAD};
    mem_r_ena_i  = ~st;
    mem_w_ena_i  = st;
    mem_r_addr_i = addr;
    mem_w_addr_i = addr;
    mem_w_data_i = wd;
    reg_w_ena_i  = 1'b1;
    reg_w_addr_i = rd;
    reg_w_data_i = 32'h5A5A_5A5A;
    bus_rdata_i  = rword;
    if (!st) sb.push_back('{rd: rd, data: exp_res, cyc: cyc + waits + 1});
    for (int k = 0; k <= waits; k++) begin
      bus_ack_i = (k == waits);
      @(negedge clk);
      check("acc_req",  {31'd0, bus_req_o}, 32'd1);
      check("acc_we",   {31'd0, bus_we_o}, {31'd0, st});
      check("acc_addr", bus_addr_o, {addr[31:2], 2'b00});
      check("acc_be",   {28'd0, bus_be_o}, {28'd0, exp_be});
      check("acc_hold", {31'd0, hold_o}, (k != waits) ? 32'd1 : 32'd0);
      if (st) check("acc_wdata", bus_wdata_o, exp_wd);
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    arst_n = 1'b0;
    idle_inputs();
    mem_r_ena_i = 1'b1;               // request present during reset
    @(negedge clk);
    check("rst_req",      {31'd0, bus_req_o}, 32'd0);
    check("rst_wb_ena",   {31'd0, reg_w_ena_o}, 32'd0);
    check("rst_wb_addr",  {27'd0, reg_w_addr_o}, 32'd0);
    check("rst_wb_data",  reg_w_data_o, 32'd0);
    check("rst_bus_err",  {31'd0, bus_err_o}, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    next_cycle();
    idle_inputs();
    arst_n = 1'b1;
    next_cycle();

    // LB at 0x103, zero-wait ack
    access(1'b0, F3_LB, 32'h103, 32'd0, 32'h80FF_1234, 5'd5, 0, 4'b1000, 32'd0, 32'hFFFF_FF80);

    // SH at 0x202, ack after three stalled cycles; store never writes back
    access(1'b1, F3_SH, 32'h202, 32'h0000_BEEF, 32'd0, 5'd7, 3, 4'b1100, 32'hBEEF_BEEF, 32'd0);
    @(negedge clk);
    check("sh_no_wb", {31'd0, reg_w_ena_o}, 32'd0);
    next_cycle();

    // Assorted loads and stores with varying wait states
    access(1'b1, F3_SB, 32'h301, 32'h0000_00AB, 32'd0, 5'd6, 1, 4'b0010, 32'hABAB_ABAB, 32'd0);
    access(1'b0, F3_LH,  32'h102, 32'd0, 32'h8001_0000, 5'd8,  1, 4'b1100, 32'd0, 32'hFFFF_8001);
    access(1'b0, F3_LHU, 32'h100, 32'd0, 32'h1234_F00D, 5'd10, 2, 4'b0011, 32'd0, 32'h0000_F00D);
    access(1'b0, F3_LBU, 32'h101, 32'd0, 32'h0000_9A00, 5'd11, 0, 4'b0010, 32'd0, 32'h0000_009A);
    access(1'b0, F3_LW,  32'h104, 32'd0, 32'hDEAD_BEEF, 5'd12, 1, 4'b1111, 32'd0, 32'hDEAD_BEEF);
    access(1'b0, 3'd3,   32'h108, 32'd0, 32'hFFFF_FFFF, 5'd13, 0, 4'b1111, 32'd0, 32'd0);
    access(1'b1, F3_SW,  32'h10C, 32'h0102_0304, 32'd0, 5'd14, 0, 4'b1111, 32'h0102_0304, 32'd0);

    // LHU at 0x002 with no ack: request lasts 16 cycles, then a bus error
    inst_i       = {17'd0, F3_LHU, 5'd0, OPC_LOAD};
    mem_r_ena_i  = 1'b1;
    mem_r_addr_i = 32'h002;
    reg_w_ena_i  = 1'b1;
    reg_w_addr_i = 5'd9;
    @(negedge clk);
    check("to_req_first", {31'd0, bus_req_o}, 32'd1);
    check("to_be",        {28'd0, bus_be_o}, 32'h0000_000C);
    for (int k = 1; k < 16; k++) begin
      next_cycle();
      @(negedge clk);
      check("to_req",  {31'd0, bus_req_o}, 32'd1);
      check("to_hold", {31'd0, hold_o}, 32'd1);
      check("to_err_early", {31'd0, bus_err_o}, 32'd0);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("to_req_drop", {31'd0, bus_req_o}, 32'd0);
    check("to_hold_rel", {31'd0, hold_o}, 32'd0);
    check("to_err",      {31'd0, bus_err_o}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("to_err_pulse", {31'd0, bus_err_o}, 32'd0);
    next_cycle();

    // LW at 0x001
`ifdef LSU_MISALIGN_TRAP_EN
    inst_i       = {17'd0, F3_LW, 5'd0, OPC_LOAD};
    mem_r_ena_i  = 1'b1;
    mem_r_addr_i = 32'h001;
    reg_w_ena_i  = 1'b1;
    reg_w_addr_i = 5'd4;
    @(negedge clk);
    check("mis_req",  {31'd0, bus_req_o}, 32'd0);
    check("mis_hold", {31'd0, hold_o}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("mis_pulse", {31'd0, misalign_o}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
    next_cycle();
`else
    access(1'b0, F3_LW, 32'h001, 32'd0, 32'hCAFE_F00D, 5'd4, 1, 4'b1111, 32'd0, 32'hCAFE_F00D);
    @(negedge clk);
    check("mis_tied", {31'd0, misalign_o}, 32'd0);
    next_cycle();
`endif

    // Acknowledge with no request outstanding is ignored
    bus_ack_i = 1'b1;
    @(negedge clk);
    check("stray_ack_req",  {31'd0, bus_req_o}, 32'd0);
    check("stray_ack_hold", {31'd0, hold_o}, 32'd0);
    next_cycle();
    idle_inputs();

    // Store and load requested together: the store wins
    inst_i       = {17'd0, F3_SW, 5'd0, OPC_STORE};
    mem_r_ena_i  = 1'b1;
    mem_w_ena_i  = 1'b1;
    mem_r_addr_i = 32'h400;
    mem_w_addr_i = 32'h300;
    mem_w_data_i = 32'h1122_3344;
    reg_w_ena_i  = 1'b1;
    reg_w_addr_i = 5'd15;
    bus_ack_i    = 1'b1;
    @(negedge clk);
    check("both_we",    {31'd0, bus_we_o}, 32'd1);
    check("both_addr",  bus_addr_o, 32'h300);
    check("both_wdata", bus_wdata_o, 32'h1122_3344);
    next_cycle();
    idle_inputs();

    // Reset during the second WAIT cycle
    inst_i       = {17'd0, F3_LW, 5'd0, OPC_LOAD};
    mem_r_ena_i  = 1'b1;
    mem_r_addr_i = 32'h040;
    reg_w_ena_i  = 1'b1;
    reg_w_addr_i = 5'd2;
    @(negedge clk);
    check("rw_req", {31'd0, bus_req_o}, 32'd1);
    next_cycle();
    next_cycle();
    arst_n = 1'b0;
    #1;
    check("rw_req_drop", {31'd0, bus_req_o}, 32'd0);
    check("rw_hold",     {31'd0, hold_o}, 32'd0);
    idle_inputs();
    @(negedge clk);
    check("rw_no_wb", {31'd0, reg_w_ena_o}, 32'd0);
    next_cycle();
    arst_n = 1'b1;

    // ADD after reset: result passes through with one cycle of latency
    reg_w_ena_i  = 1'b1;
    reg_w_addr_i = 5'd3;
    reg_w_data_i = 32'h1234_5678;
    sb.push_back('{rd: 5'd3, data: 32'h1234_5678, cyc: cyc + 1});
    @(negedge clk);
    check("add_req", {31'd0, bus_req_o}, 32'd0);
    next_cycle();
    idle_inputs();

    repeat (3) next_cycle();
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
